pkt_cap_rx: RTL and testbench

PKT_CAP_RX -- requirements
Module: pkt_cap_rx

---
 rtl/pkt_cap_rx.sv | 111 +++++++++++
 tb/tb_pkt_cap_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_cap_rx.sv
// pkt_cap_rx: packet capture receiver; beats go to a data FIFO, a timestamp/length/flags word goes to a meta FIFO.
// Define PKT_CAP_RX_SNAPLEN_EN to add snaplen_i truncation.
module pkt_cap_rx #(
    parameter int          DATA_W   = 64,
    parameter int          LEN_W    = 16,
    parameter int          TS_W     = 64,
    parameter int unsigned TS_MUL   = 819,
    parameter int          TS_SHIFT = 7,
    parameter int          CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     active_i,
    input  logic [DATA_W-1:0]        in_dat_i,
    input  logic                     in_vld_i,
    input  logic                     in_sop_i,
    input  logic                     in_eop_i,
    input  logic [LEN_W-1:0]         in_len_i,
    input  logic [TS_W-1:0]          ts_cnt_i,
    input  logic [TS_W-1:0]          base_time_i,
`ifdef PKT_CAP_RX_SNAPLEN_EN
    input  logic [LEN_W-1:0]         snaplen_i,
`endif
    output logic [DATA_W-1:0]        data_din_o,
    output logic                     data_wr_en_o,
    input  logic                     data_full_i,
    output logic [TS_W+LEN_W+7:0]    meta_din_o,
    output logic                     meta_wr_en_o,
    input  logic                     meta_full_i,
    output logic [CNT_W-1:0]         pkt_cnt_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     meta_lost_o
);
    localparam logic [1:0] IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2;
    localparam int PW = TS_W + 32;
    localparam int MW = TS_W + LEN_W + 8;
    localparam int BYTES = DATA_W / 8;

    logic [1:0] state;
    logic ovf, snap, snap_hit;
    logic [LEN_W-1:0] bcnt;
    logic sop_ok, blocked, in_pass, ovf_hit, wr, eop_v, pass_eop, drop_eop;
    logic m1_vld, m2_vld;
    logic [PW-1:0] m1_prod;
    logic [TS_W-1:0] m1_base;
    logic [LEN_W-1:0] m1_len;
    logic [7:0] m1_flags;
    logic [MW-1:0] m2_word, meta_last;

`ifdef PKT_CAP_RX_SNAPLEN_EN
    logic [LEN_W:0] snap_lim;
    assign snap_lim = ({1'b0, snaplen_i} + (LEN_W+1)'(BYTES - 1)) / (LEN_W+1)'(BYTES);
    // bcnt counts beats already seen in this packet, so the beat now offered is number bcnt+1
    assign snap_hit = snaplen_i != '0 && {1'b0, bcnt} >= snap_lim;
`else
    assign snap_hit = 1'b0;
`endif

    always_comb begin
        eop_v    = in_vld_i && in_eop_i;
        sop_ok   = state == IDLE && in_vld_i && in_sop_i && active_i;
        blocked  = data_full_i || meta_full_i;
        in_pass  = state == PASS && in_vld_i;
        ovf_hit  = in_pass && !ovf && !snap_hit && data_full_i;
        wr       = (sop_ok && !blocked) || (in_pass && !ovf && !snap_hit && !data_full_i);
        pass_eop = eop_v && ((sop_ok && !blocked) || state == PASS);
        drop_eop = eop_v && ((sop_ok && blocked) || state == DROP);
    end

    // Meta write sees the FIFO full flag in the same cycle; a skipped word leaves the output unchanged.
    assign meta_wr_en_o = m2_vld && !meta_full_i;
    assign meta_din_o   = meta_wr_en_o ? m2_word : meta_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ovf          <= 1'b0;
            snap         <= 1'b0;
            bcnt         <= '0;
            data_wr_en_o <= 1'b0;
            data_din_o   <= '0;
            pkt_cnt_o    <= '0;
            drop_cnt_o   <= '0;
            m1_vld       <= 1'b0;
            m2_vld       <= 1'b0;
            meta_last    <= '0;
            meta_lost_o  <= 1'b0;
        end else begin
            data_wr_en_o <= wr;
            if (wr) data_din_o <= in_dat_i;
            if (sop_ok) state <= in_eop_i ? IDLE : blocked ? DROP : PASS;
            else if (state != IDLE && eop_v) state <= IDLE;
            ovf  <= state == PASS && !eop_v && (ovf || ovf_hit);
            snap <= state == PASS && !eop_v && (snap || (in_pass && snap_hit));
            bcnt <= sop_ok ? LEN_W'(1) : (in_pass && bcnt != '1) ? bcnt + 1'b1 : bcnt;
            pkt_cnt_o  <= pkt_cnt_o + CNT_W'(pass_eop);
            drop_cnt_o <= drop_cnt_o + CNT_W'(drop_eop);
            m1_vld <= pass_eop;
            if (pass_eop) begin
                m1_prod  <= PW'(ts_cnt_i) * PW'(TS_MUL);
                m1_base  <= base_time_i;
                m1_len   <= in_len_i;
                m1_flags <= {6'b0, snap || (in_pass && snap_hit), ovf || ovf_hit};
            end
            m2_vld <= m1_vld;
            if (m1_vld) m2_word <= {m1_flags, m1_len, TS_W'(m1_prod >> TS_SHIFT) + m1_base};
            meta_last <= meta_din_o;
            if (m2_vld && meta_full_i) meta_lost_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pkt_cap_rx.sv
// tb_pkt_cap_rx: directed and randomized checks of pkt_cap_rx against a packet-level reference model.
module tb_pkt_cap_rx;
    localparam int DW = 64, LW = 16, TW = 64, CW = 8, MW = TW + LW + 8;

    logic clk = 0, rst = 1, active_i = 0, in_vld_i = 0, in_sop_i = 0, in_eop_i = 0;
    logic data_full_i = 0, meta_full_i = 0;
    logic [DW-1:0] in_dat_i = '0;
    logic [LW-1:0] in_len_i = '0;
    logic [TW-1:0] ts_cnt_i = '0, base_time_i = '0;
`ifdef PKT_CAP_RX_SNAPLEN_EN
    logic [LW-1:0] snaplen_i = '0;
`endif
    logic [DW-1:0] data_din_o;
    logic data_wr_en_o, meta_wr_en_o, meta_lost_o;
    logic [MW-1:0] meta_din_o;
    logic [CW-1:0] pkt_cnt_o, drop_cnt_o;

    int checks = 0, failures = 0, cyc = 0;
    logic [DW-1:0] got_d[$];
    int got_dc[$];
    logic [MW-1:0] got_m[$];
    int got_mc[$];
    bit mf_hist[int];

    pkt_cap_rx #(.DATA_W(DW), .LEN_W(LW), .TS_W(TW), .TS_MUL(819), .TS_SHIFT(7), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .active_i(active_i),
        .in_dat_i(in_dat_i), .in_vld_i(in_vld_i), .in_sop_i(in_sop_i), .in_eop_i(in_eop_i),
        .in_len_i(in_len_i), .ts_cnt_i(ts_cnt_i), .base_time_i(base_time_i),
`ifdef PKT_CAP_RX_SNAPLEN_EN
        .snaplen_i(snaplen_i),
`endif
        .data_din_o(data_din_o), .data_wr_en_o(data_wr_en_o), .data_full_i(data_full_i),
        .meta_din_o(meta_din_o), .meta_wr_en_o(meta_wr_en_o), .meta_full_i(meta_full_i),
        .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o), .meta_lost_o(meta_lost_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_wr_en_o) begin got_d.push_back(data_din_o); got_dc.push_back(cyc); end
        if (meta_wr_en_o) begin got_m.push_back(meta_din_o); got_mc.push_back(cyc); end
    end

    function automatic bit rb(input int n);
        return $urandom_range(0, n - 1) == 0;
    endfunction

    // Reference meta word: ts = ((cnt*819) >> 7) + base, all modulo 2^64.
    function automatic logic [MW-1:0] mword(input logic [TW-1:0] cnt, input logic [TW-1:0] base,
                                            input logic [LW-1:0] len, input logic [7:0] fl);
        logic [127:0] p;
        logic [TW-1:0] ts;
        p = {64'b0, cnt} * 128'd819;
        ts = TW'(p >> 7) + base;
        return {fl, len, ts};
    endfunction

    // Drives one cycle of inputs; en returns the cycle index of the edge that captured them.
    task automatic beat(input logic v, input logic s, input logic e, input logic [DW-1:0] d,
                        input logic [LW-1:0] l, input logic df, input logic mf, input logic act,
                        output int en);
        in_vld_i = v; in_sop_i = s; in_eop_i = e; in_dat_i = d; in_len_i = l;
        data_full_i = df; meta_full_i = mf; active_i = act;
        @(posedge clk);
        #1;
        en = cyc;
        mf_hist[en] = mf;
    endtask

    task automatic idle(input int n);
        int en;
        repeat (n) beat(0, 0, 0, '0, '0, 0, 0, 1, en);
    endtask

    task automatic do_reset;
        rst = 1;
        idle(3);
        rst = 0;
        got_d.delete(); got_dc.delete(); got_m.delete(); got_mc.delete();
    endtask

    task automatic test_reset;
        int en;
        rst = 1;
        beat(1, 1, 1, 64'h1234, 16'd8, 0, 0, 1, en);
        idle(3);
        checks++; if (data_wr_en_o !== 1'b0) begin failures++; $display("FAIL rst_data_wr_en got=%0b exp=0", data_wr_en_o); end
        checks++; if (data_din_o !== '0) begin failures++; $display("FAIL rst_data_din got=%0h exp=0", data_din_o); end
        checks++; if (meta_wr_en_o !== 1'b0) begin failures++; $display("FAIL rst_meta_wr_en got=%0b exp=0", meta_wr_en_o); end
        checks++; if (meta_din_o !== '0) begin failures++; $display("FAIL rst_meta_din got=%0h exp=0", meta_din_o); end
        checks++; if (pkt_cnt_o !== '0 || drop_cnt_o !== '0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", pkt_cnt_o, drop_cnt_o); end
        checks++; if (meta_lost_o !== 1'b0) begin failures++; $display("FAIL rst_meta_lost got=%0b exp=0", meta_lost_o); end
    endtask

    task automatic test_basic;
        logic [DW-1:0] d[3];
        int e[3];
        do_reset;
        foreach (d[i]) d[i] = {$urandom, $urandom};
        ts_cnt_i = 64'd1280; base_time_i = 64'd1000;
        beat(1, 1, 0, d[0], '0, 0, 0, 1, e[0]);
        beat(1, 0, 0, d[1], '0, 0, 0, 1, e[1]);
        checks++; if (pkt_cnt_o !== 8'd0) begin failures++; $display("FAIL basic_pkt_early got=%0d exp=0", pkt_cnt_o); end
        beat(1, 0, 1, d[2], 16'd20, 0, 0, 1, e[2]);
        checks++; if (pkt_cnt_o !== 8'd1) begin failures++; $display("FAIL basic_pkt_t1 got=%0d exp=1", pkt_cnt_o); end
        idle(4);
        checks++; if (got_d.size() != 3) begin failures++; $display("FAIL basic_data_count got=%0d exp=3", got_d.size()); end
        foreach (d[i]) if (i < got_d.size()) begin
            checks++; if (got_d[i] !== d[i] || got_dc[i] != e[i]) begin failures++; $display("FAIL basic_data%0d got=%0h@%0d exp=%0h@%0d", i, got_d[i], got_dc[i], d[i], e[i]); end
        end
        checks++; if (got_m.size() != 1) begin failures++; $display("FAIL basic_meta_count got=%0d exp=1", got_m.size()); end
        else begin
            checks++; if (got_m[0] !== {8'h00, 16'd20, 64'd9190}) begin failures++; $display("FAIL basic_meta_word got=%0h exp=%0h", got_m[0], {8'h00, 16'd20, 64'd9190}); end
            checks++; if (got_mc[0] != e[2] + 1) begin failures++; $display("FAIL basic_meta_cycle got=%0d exp=%0d", got_mc[0], e[2] + 1); end
        end
        checks++; if (data_wr_en_o !== 1'b0 || data_din_o !== d[2]) begin failures++; $display("FAIL basic_data_hold got=%0h exp=%0h", data_din_o, d[2]); end
        checks++; if (meta_wr_en_o !== 1'b0 || meta_din_o !== {8'h00, 16'd20, 64'd9190}) begin failures++; $display("FAIL basic_meta_hold got=%0h", meta_din_o); end
    endtask

    task automatic test_data_full_sop;
        int e[3];
        do_reset;
        beat(1, 1, 0, 64'hA1, '0, 1, 0, 1, e[0]);
        beat(1, 0, 0, 64'hA2, '0, 0, 0, 1, e[1]);
        checks++; if (drop_cnt_o !== 8'd0) begin failures++; $display("FAIL dfs_drop_early got=%0d exp=0", drop_cnt_o); end
        beat(1, 0, 1, 64'hA3, 16'd24, 0, 0, 1, e[2]);
        checks++; if (drop_cnt_o !== 8'd1) begin failures++; $display("FAIL dfs_drop_t1 got=%0d exp=1", drop_cnt_o); end
        idle(4);
        checks++; if (got_d.size() != 0 || got_m.size() != 0) begin failures++; $display("FAIL dfs_writes got=%0d/%0d exp=0/0", got_d.size(), got_m.size()); end
        checks++; if (pkt_cnt_o !== 8'd0 || drop_cnt_o !== 8'd1) begin failures++; $display("FAIL dfs_counts got=%0d/%0d exp=0/1", pkt_cnt_o, drop_cnt_o); end
    endtask

    task automatic test_ovf;
        logic [DW-1:0] d0;
        int en;
        bit dfp[4] = '{0, 1, 1, 0};
        do_reset;
        d0 = {$urandom, $urandom};
        ts_cnt_i = {$urandom, $urandom}; base_time_i = {$urandom, $urandom};
        for (int b = 0; b < 4; b++)
            beat(1, b == 0, b == 3, b == 0 ? d0 : {$urandom, $urandom}, 16'd30, dfp[b], 0, 1, en);
        idle(4);
        checks++; if (got_d.size() != 1 || got_d[0] !== d0) begin failures++; $display("FAIL ovf_data got=%0d writes exp=1 (%0h)", got_d.size(), d0); end
        checks++; if (got_m.size() != 1 || got_m[0] !== mword(ts_cnt_i, base_time_i, 16'd30, 8'h01)) begin failures++; $display("FAIL ovf_meta got=%0h exp=%0h", got_m.size() ? got_m[0] : '0, mword(ts_cnt_i, base_time_i, 16'd30, 8'h01)); end
        checks++; if (pkt_cnt_o !== 8'd1) begin failures++; $display("FAIL ovf_pkt got=%0d exp=1", pkt_cnt_o); end
    endtask

    task automatic test_meta_full;
        int ea, eb, en;
        logic [MW-1:0] wb;
        do_reset;
        ts_cnt_i = {$urandom, $urandom}; base_time_i = {$urandom, $urandom};
        beat(1, 1, 1, 64'hB1, 16'd5, 0, 0, 1, ea);
        beat(0, 0, 0, '0, '0, 0, 0, 1, en);
        beat(0, 0, 0, '0, '0, 0, 1, 1, en);
        idle(2);
        checks++; if (meta_lost_o !== 1'b1) begin failures++; $display("FAIL mf_lost_set got=%0b exp=1", meta_lost_o); end
        ts_cnt_i = {$urandom, $urandom}; base_time_i = {$urandom, $urandom};
        wb = mword(ts_cnt_i, base_time_i, 16'd9, 8'h00);
        beat(1, 1, 1, 64'hB2, 16'd9, 0, 0, 1, eb);
        idle(4);
        checks++; if (got_m.size() != 1 || got_m[0] !== wb || got_mc[0] != eb + 1) begin failures++; $display("FAIL mf_next_meta got=%0d words exp=1 word %0h", got_m.size(), wb); end
        checks++; if (meta_lost_o !== 1'b1) begin failures++; $display("FAIL mf_lost_held got=%0b exp=1", meta_lost_o); end
        checks++; if (pkt_cnt_o !== 8'd2 || got_d.size() != 2) begin failures++; $display("FAIL mf_pkt got=%0d/%0d exp=2/2", pkt_cnt_o, got_d.size()); end
    endtask

    task automatic test_back_to_back;
        logic [MW-1:0] exp_m[$];
        int en;
        do_reset;
        for (int i = 0; i < 10; i++) begin
            logic [LW-1:0] l;
            l = LW'($urandom);
            ts_cnt_i = {$urandom, $urandom}; base_time_i = {$urandom, $urandom};
            exp_m.push_back(mword(ts_cnt_i, base_time_i, l, 8'h00));
            beat(1, 1, 1, {$urandom, $urandom}, l, 0, 0, 1, en);
        end
        idle(4);
        checks++; if (got_d.size() != 10 || got_m.size() != 10) begin failures++; $display("FAIL b2b_writes got=%0d/%0d exp=10/10", got_d.size(), got_m.size()); end
        foreach (exp_m[i]) if (i < got_m.size()) begin
            checks++; if (got_m[i] !== exp_m[i]) begin failures++; $display("FAIL b2b_meta%0d got=%0h exp=%0h", i, got_m[i], exp_m[i]); end
        end
        checks++; if (pkt_cnt_o !== 8'd10) begin failures++; $display("FAIL b2b_pkt got=%0d exp=10", pkt_cnt_o); end
        repeat (245) beat(1, 1, 1, {$urandom, $urandom}, 16'd1, 0, 0, 1, en);
        idle(2);
        checks++; if (pkt_cnt_o !== 8'hFF) begin failures++; $display("FAIL wrap_full got=%0d exp=255", pkt_cnt_o); end
        beat(1, 1, 1, 64'hC1, 16'd1, 0, 0, 1, en);
        idle(2);
        checks++; if (pkt_cnt_o !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", pkt_cnt_o); end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] d0;
        int en;
        do_reset;
        d0 = {$urandom, $urandom};
        beat(1, 1, 0, d0, '0, 0, 0, 1, en);
        rst = 1;
        beat(1, 0, 0, 64'hD2, '0, 0, 0, 1, en);
        rst = 0;
        beat(1, 0, 1, 64'hD3, 16'd20, 0, 0, 1, en);
        idle(4);
        checks++; if (got_d.size() != 1 || got_d[0] !== d0) begin failures++; $display("FAIL rstmid_data got=%0d writes exp=1", got_d.size()); end
        checks++; if (got_m.size() != 0) begin failures++; $display("FAIL rstmid_meta got=%0d exp=0", got_m.size()); end
        checks++; if (pkt_cnt_o !== 8'd0 || drop_cnt_o !== 8'd0) begin failures++; $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", pkt_cnt_o, drop_cnt_o); end
    endtask

`ifdef PKT_CAP_RX_SNAPLEN_EN
    task automatic test_snap;
        logic [DW-1:0] d0;
        int en;
        do_reset;
        snaplen_i = 16'd8;
        d0 = {$urandom, $urandom};
        ts_cnt_i = {$urandom, $urandom}; base_time_i = {$urandom, $urandom};
        for (int b = 0; b < 3; b++) beat(1, b == 0, b == 2, b == 0 ? d0 : {$urandom, $urandom}, 16'd20, 0, 0, 1, en);
        idle(4);
        snaplen_i = '0;
        checks++; if (got_d.size() != 1 || got_d[0] !== d0) begin failures++; $display("FAIL snap_data got=%0d writes exp=1", got_d.size()); end
        checks++; if (got_m.size() != 1 || got_m[0] !== mword(ts_cnt_i, base_time_i, 16'd20, 8'h02)) begin failures++; $display("FAIL snap_meta got=%0d words exp=1 flags=02", got_m.size()); end
    endtask
`endif

    task automatic test_random;
        logic [MW-1:0] pend_w[$], exp_m[$];
        logic [DW-1:0] exp_d[$];
        int pend_e[$];
        int pk, dr, en;
        bit lost;
        pk = 0; dr = 0; lost = 0;
        do_reset;
        for (int p = 0; p < 60; p++) begin
            int nb;
            bit act, acc, wrt, ovf;
            nb = $urandom_range(1, 5);
            act = !rb(8);
            acc = 0; wrt = 0; ovf = 0;
            repeat ($urandom_range(0, 2)) beat(rb(2), 0, rb(2), {$urandom, $urandom}, '0, rb(2), rb(2), rb(2), en);
            for (int b = 0; b < nb; b++) begin
                logic [DW-1:0] d;
                logic [LW-1:0] l;
                bit df, mf, last;
                d = {$urandom, $urandom}; l = LW'($urandom);
                df = rb(6); mf = rb(6); last = b == nb - 1;
                if (last) begin ts_cnt_i = {$urandom, $urandom}; base_time_i = {$urandom, $urandom}; end
                beat(1, b == 0, last, d, l, df, mf, b == 0 ? act : rb(2), en);
                if (b == 0) begin acc = act && !df && !mf; wrt = acc; end
                else if (wrt && df) begin wrt = 0; ovf = 1; end
                if (wrt) exp_d.push_back(d);
                if (last && acc) begin pk++; pend_w.push_back(mword(ts_cnt_i, base_time_i, l, {7'b0, ovf})); pend_e.push_back(en); end
                if (last && act && !acc) dr++;
            end
        end
        idle(5);
        foreach (pend_w[i]) if (mf_hist[pend_e[i] + 2]) lost = 1; else exp_m.push_back(pend_w[i]);
        checks++; if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL rnd_data_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            checks++; if (got_d[i] !== exp_d[i]) begin failures++; $display("FAIL rnd_data%0d got=%0h exp=%0h", i, got_d[i], exp_d[i]); end
        end
        checks++; if (got_m.size() != exp_m.size()) begin failures++; $display("FAIL rnd_meta_count got=%0d exp=%0d", got_m.size(), exp_m.size()); end
        foreach (exp_m[i]) if (i < got_m.size()) begin
            checks++; if (got_m[i] !== exp_m[i]) begin failures++; $display("FAIL rnd_meta%0d got=%0h exp=%0h", i, got_m[i], exp_m[i]); end
        end
        checks++; if (pkt_cnt_o !== CW'(pk) || drop_cnt_o !== CW'(dr)) begin failures++; $display("FAIL rnd_counts got=%0d/%0d exp=%0d/%0d", pkt_cnt_o, drop_cnt_o, pk, dr); end
        checks++; if (meta_lost_o !== lost) begin failures++; $display("FAIL rnd_meta_lost got=%0b exp=%0b", meta_lost_o, lost); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_data_full_sop;
        test_ovf;
        test_meta_full;
        test_back_to_back;
        test_reset_mid;
`ifdef PKT_CAP_RX_SNAPLEN_EN
        test_snap;
`endif
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
